// File: rtl/ibex_mem_arbiter.sv
// Shares one external memory bus between the ibex instruction and data ports.
// Optional MEM_ARB_FAIRNESS_EN forces an instr grant after StarveLim waiting cycles.
module ibex_mem_arbiter #(
  parameter int unsigned AW        = 7,
  parameter int unsigned DW        = 4,
  parameter int unsigned MaxOutst  = 2,
  parameter int unsigned StarveLim = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [AW-1:0] instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [DW-1:0] instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_err_i,
  output logic          spurious_o
);

  localparam int unsigned PW =
    (MaxOutst > 1) ? $clog2(MaxOutst) : 1;
  localparam int unsigned CW = $clog2(MaxOutst + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_I,
    HOLD_D
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q [MaxOutst];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          spur_q;

  logic sel_i, sel_d;
  logic slot_ok;
  logic push, pop;
  logic head;
  logic instr_first;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(MaxOutst - 1)) return '0;
    return p + PW'(1);
  endfunction

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned SW = $clog2(StarveLim + 1);
  logic [SW-1:0] starve_q;

  assign instr_first =
    instr_req_i && (starve_q >= SW'(StarveLim));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (!instr_req_i || instr_gnt_o) begin
      starve_q <= '0;
    end else if (starve_q < SW'(StarveLim)) begin
      starve_q <= starve_q + SW'(1);
    end
  end
`else
  assign instr_first = 1'b0;
`endif

  // A response in this cycle frees a slot for a grant in the same cycle.
  assign pop     = mem_rvalid_i && (cnt_q != '0) && !rst_i;
  assign slot_ok = (cnt_q < CW'(MaxOutst)) || pop;
  assign head    = owner_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    sel_i   = 1'b0;
    sel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i && !instr_first) sel_d = 1'b1;
        else if (instr_req_i)           sel_i = 1'b1;
      end
      HOLD_I: begin
        if (!instr_req_i) state_d = IDLE;
        else              sel_i   = 1'b1;
      end
      HOLD_D: begin
        if (!data_req_i) state_d = IDLE;
        else             sel_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (mem_req_o) begin
      if (mem_gnt_i)  state_d = IDLE;
      else if (sel_d) state_d = HOLD_D;
      else            state_d = HOLD_I;
    end
  end

  assign mem_req_o = (sel_i || sel_d) && slot_ok && !rst_i;
  assign push      = mem_req_o && mem_gnt_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      unique case (1'b1)
        sel_d: begin
          mem_we_o    = data_we_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end
        sel_i: begin
          mem_addr_o  = instr_addr_i;
        end
        default: ;
      endcase
    end
  end

  assign instr_gnt_o = push && sel_i;
  assign data_gnt_o  = push && sel_d;

  assign instr_rvalid_o = pop && !head;
  assign data_rvalid_o  = pop && head;

  assign instr_rdata_o =
    instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o =
    data_rvalid_o ? mem_rdata_i : '0;
  assign instr_err_o = instr_rvalid_o && mem_err_i;
  assign data_err_o  = data_rvalid_o && mem_err_i;

  assign spurious_o = spur_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      spur_q   <= 1'b0;
      for (int i = 0; i < int'(MaxOutst); i++) begin
        owner_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (push) begin
        owner_q[wr_ptr_q] <= sel_d;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      if (mem_rvalid_i && (cnt_q == '0)) spur_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_ibex_mem_arbiter;

  localparam int AW = 7;
  localparam int DW = 4;
  localparam int MO = 2;
  localparam int SL = 8;

  logic          clk, rst;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_we_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [DW-1:0] mem_rdata_i;
  logic          spurious_o;

  int checks = 0;
  int errors = 0;

  ibex_mem_arbiter #(
    .AW(AW), .DW(DW), .MaxOutst(MO), .StarveLim(SL)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .spurious_o     (spurious_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs packed: 28 bits.
  function automatic logic [27:0] outs();
    return {mem_req_o, mem_we_o, mem_addr_o,
            mem_wdata_o, instr_gnt_o, data_gnt_o,
            instr_rvalid_o, instr_rdata_o, instr_err_o,
            data_rvalid_o, data_rdata_o, data_err_o,
            spurious_o};
  endfunction

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    mem_gnt_i = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (outs() !== 28'h0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs() !== 28'h0) begin
      errors++;
      $display("FAIL idle_outs got %h exp 0", outs());
    end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_instr_read();
    do_reset();
    @(negedge clk);
    instr_req_i = 1'b1;
    instr_addr_i = 7'h15;
    mem_gnt_i = 1'b1;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o,
         mem_we_o, mem_addr_o} !== {4'b1010, 7'h15}) begin
      errors++;
      $display("FAIL instr_grant got %b%b%b%b %h",
        instr_gnt_o, data_gnt_o, mem_req_o,
        mem_we_o, mem_addr_o);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 4'hA;
    #1;
    checks++;
    if ({instr_rvalid_o, instr_rdata_o, data_rvalid_o,
         data_rdata_o} !== {1'b1, 4'hA, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL instr_resp got %b %h %b %h exp 1 a 0 0",
        instr_rvalid_o, instr_rdata_o,
        data_rvalid_o, data_rdata_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    @(negedge clk);
    instr_req_i  = 1'b1;
    instr_addr_i = 7'h44;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_addr_i  = 7'h03;
    data_wdata_i = 4'h5;
    for (int c = 0; c < 4; c++) begin
      mem_gnt_i = (c == 3);
      #1;
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           instr_gnt_o, data_gnt_o} !==
          {2'b11, 7'h03, 4'h5, 1'b0, (c == 3)}) begin
        errors++;
        $display("FAIL hold_c%0d got %b%b %h %h %b%b",
          c, mem_req_o, mem_we_o, mem_addr_o,
          mem_wdata_o, instr_gnt_o, data_gnt_o);
      end
      @(negedge clk);
    end
    data_req_i = 1'b0;
    instr_req_i = 1'b0;
    mem_gnt_i = 1'b0;
    // Held requester drops: no grant, not even to the other side.
    @(negedge clk);
    instr_req_i = 1'b1;
    @(negedge clk);
    instr_req_i = 1'b0;
    data_req_i  = 1'b1;
    mem_gnt_i   = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b000) begin
      errors++;
      $display("FAIL hold_drop got %b%b%b exp 000",
        mem_req_o, instr_gnt_o, data_gnt_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_then_data got %b exp 1", data_gnt_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    @(negedge clk);
    instr_req_i = 1'b1;
    instr_addr_i = 7'h01;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    instr_req_i = 1'b0;
    data_req_i = 1'b1;
    data_addr_i = 7'h02;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL full_second got %b exp 1", data_gnt_o);
    end
    @(negedge clk);
    data_req_i = 1'b0;
    instr_req_i = 1'b1;
    instr_addr_i = 7'h07;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({mem_req_o, instr_gnt_o} !== 2'b00) begin
        errors++;
        $display("FAIL full_block%0d got %b%b exp 00",
          c, mem_req_o, instr_gnt_o);
      end
      @(negedge clk);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 4'h1;
    #1;
    checks++;
    if ({mem_req_o, instr_gnt_o, instr_rvalid_o,
         instr_rdata_o, data_rvalid_o} !== 8'b1110_0010) begin
      errors++;
      $display("FAIL full_pop_push got %b%b%b %h %b exp 111 1 0",
        mem_req_o, instr_gnt_o, instr_rvalid_o,
        instr_rdata_o, data_rvalid_o);
    end
    @(negedge clk);
    instr_req_i = 1'b0;
    mem_rdata_i = 4'h2;
    mem_err_i = 1'b1;
    #1;
    checks++;
    if ({data_rvalid_o, data_rdata_o, data_err_o,
         instr_rvalid_o} !== 7'b1_0010_1_0) begin
      errors++;
      $display("FAIL order_data got %b %h %b %b exp 1 2 1 0",
        data_rvalid_o, data_rdata_o, data_err_o,
        instr_rvalid_o);
    end
    @(negedge clk);
    mem_rdata_i = 4'h3;
    mem_err_i = 1'b0;
    #1;
    checks++;
    if ({instr_rvalid_o, instr_rdata_o,
         data_rvalid_o} !== 6'b1_0011_0) begin
      errors++;
      $display("FAIL order_third got %b %h %b exp 1 3 0",
        instr_rvalid_o, instr_rdata_o, data_rvalid_o);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (spurious_o !== 1'b0) begin
      errors++;
      $display("FAIL full_no_spur got %b exp 0", spurious_o);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 4'hF;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      errors++;
      $display("FAIL spur_rvalid got %b%b exp 00",
        instr_rvalid_o, data_rvalid_o);
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (spurious_o !== 1'b1) begin
      errors++;
      $display("FAIL spur_sticky got %b exp 1", spurious_o);
    end
    // Count stayed 0: next real transaction completes normally.
    instr_req_i = 1'b1;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 4'h6;
    #1;
    checks++;
    if ({instr_rvalid_o, instr_rdata_o} !== 5'b1_0110) begin
      errors++;
      $display("FAIL spur_count got %b %h exp 1 6",
        instr_rvalid_o, instr_rdata_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    instr_req_i = 1'b1;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_lost got %b%b exp 00",
        instr_rvalid_o, data_rvalid_o);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (spurious_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_spur got %b exp 1", spurious_o);
    end
  endtask

  task automatic test_fairness();
    int first_i;
    int exp_i;
    first_i = 0;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_i = SL + 1;
`else
    exp_i = 0;
`endif
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      instr_req_i = 1'b1;
      data_req_i = 1'b1;
      mem_gnt_i = 1'b1;
      mem_rvalid_i = (c > 1);
      #1;
      if (instr_gnt_o === 1'b1 && first_i == 0) first_i = c;
    end
    checks++;
    if (first_i != exp_i) begin
      errors++;
      $display("FAIL fairness_cycle got %0d exp %0d",
        first_i, exp_i);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random(input int n);
    bit q[$];
    int lock;
    bit spur;
    int starve;
    bit pop, hd, room, gi, gd, ereq;
    int s;
    logic [27:0] exp;
    do_reset();
    lock = 0;
    spur = 0;
    starve = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      instr_req_i  = ($urandom_range(0, 3) != 0);
      instr_addr_i = AW'($urandom);
      data_req_i   = ($urandom_range(0, 2) != 0);
      data_we_i    = $urandom_range(0, 1);
      data_addr_i  = AW'($urandom);
      data_wdata_i = DW'($urandom);
      mem_gnt_i    = $urandom_range(0, 1);
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = DW'($urandom);
      mem_err_i    = ($urandom_range(0, 3) == 0);
      #1;
      pop  = mem_rvalid_i && q.size() > 0;
      hd   = pop ? q[0] : 1'b0;
      room = (q.size() < MO) || pop;
      // s: 0 none, 1 instr, 2 data
      if (lock == 0) begin
`ifdef MEM_ARB_FAIRNESS_EN
        if (instr_req_i && starve >= SL) s = 1;
        else
`endif
        if (data_req_i) s = 2;
        else if (instr_req_i) s = 1;
        else s = 0;
      end else if (lock == 1) begin
        s = instr_req_i ? 1 : 0;
      end else begin
        s = data_req_i ? 2 : 0;
      end
      ereq = (s != 0) && room;
      gi = ereq && mem_gnt_i && s == 1;
      gd = ereq && mem_gnt_i && s == 2;
      exp = {ereq,
             ereq && s == 2 && data_we_i,
             !ereq ? 7'h0 : (s == 2 ? data_addr_i : instr_addr_i),
             (ereq && s == 2) ? data_wdata_i : 4'h0,
             gi, gd,
             pop && !hd,
             (pop && !hd) ? mem_rdata_i : 4'h0,
             pop && !hd && mem_err_i,
             pop && hd,
             (pop && hd) ? mem_rdata_i : 4'h0,
             pop && hd && mem_err_i,
             spur};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL random_c%0d got %h exp %h", c, outs(), exp);
      end
      if (mem_rvalid_i && q.size() == 0) spur = 1;
      if (pop) void'(q.pop_front());
      if (gi || gd) q.push_back(gd);
      if (s == 0) lock = 0;
      else if (gi || gd) lock = 0;
      else if (ereq) lock = s;
      if (!instr_req_i || gi) starve = 0;
      else if (starve < SL) starve++;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_instr_read();
    test_hold();
    test_full();
    test_spurious();
    test_reset_mid();
    test_fairness();
    test_random(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
